// File: rtl/rgb_fade_pkg.sv
// rgb_fade_pkg: shared state encoding, default sizes and colour field positions
package rgb_fade_pkg;
    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
    localparam int PWM_W_DEF    = 8;
    localparam int STEP_DIV_DEF = 1024;
    // Field positions in cmd_color in units of PWM_W; also the channel array index
    localparam int RED_LSB   = 2;
    localparam int GREEN_LSB = 1;
    localparam int BLUE_LSB  = 0;
endpackage

// File: rtl/rgb_fade_sequencer_pwm_compare.sv
// pwm_compare: one PWM channel; duty is latched only at the counter wrap
module pwm_compare #(
    parameter int PWM_W = 8
) (
    input  logic             hw_clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] i_pcnt,
    input  logic [PWM_W-1:0] i_duty,
    output logic             o_pwm
);
    logic [PWM_W-1:0] r_cmp;
    logic             r_pwm;
    logic             w_wrap;

    assign w_wrap = &i_pcnt;
    assign o_pwm  = r_pwm;

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            if (w_wrap) r_cmp <= i_duty;
            r_pwm <= i_pcnt < r_cmp;
        end
    end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: fades three PWM duties toward commanded targets one LSB per
// step tick, holds for a commanded number of ticks, then accepts the next command.
module rgb_fade_sequencer
    import rgb_fade_pkg::*;
#(
    parameter int PWM_W    = PWM_W_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic               hw_clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3*PWM_W-1:0] cmd_color,
    input  logic [15:0]        cmd_hold,
    output logic               pwm_red,
    output logic               pwm_green,
    output logic               pwm_blue,
    output logic               busy
);
    localparam int PRE_W = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_DIV - 1);

    state_t           r_state, w_next;
    logic [PWM_W-1:0] r_pcnt;
    logic [PRE_W-1:0] r_pre;
    logic [PWM_W-1:0] r_cur [3];
    logic [PWM_W-1:0] r_tgt [3];
    logic [15:0]      r_hold;
    logic             w_accept, w_tick, w_done;
    logic [2:0]       w_pwm;

    assign cmd_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_tick    = r_pre == PRE_MAX;
    assign w_done    = (r_cur[0] == r_tgt[0]) && (r_cur[1] == r_tgt[1]) && (r_cur[2] == r_tgt[2]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? FADE : IDLE;
            FADE:    w_next = w_done ? HOLD : FADE;
            HOLD:    w_next = (r_hold == '0) ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_pre  <= '0;
            r_hold <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cur[i] <= '0;
                r_tgt[i] <= '0;
            end
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            r_pre  <= (w_accept || w_tick) ? '0 : r_pre + 1'b1;
            if (w_accept) begin
                r_hold <= cmd_hold;
                for (int i = 0; i < 3; i++) r_tgt[i] <= cmd_color[i*PWM_W +: PWM_W];
            end
            // Each channel moves independently, so cur never passes its target
            if (r_state == FADE && w_tick)
                for (int i = 0; i < 3; i++)
                    r_cur[i] <= (r_cur[i] < r_tgt[i]) ? r_cur[i] + 1'b1 :
                                (r_cur[i] > r_tgt[i]) ? r_cur[i] - 1'b1 : r_cur[i];
            if (r_state == HOLD && w_tick && r_hold != '0) r_hold <= r_hold - 16'd1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        pwm_compare #(.PWM_W(PWM_W)) u_pwm (
            .hw_clk (hw_clk),
            .rst_n  (rst_n),
            .i_pcnt (r_pcnt),
            .i_duty (r_cur[g]),
            .o_pwm  (w_pwm[g])
        );
    end

    assign pwm_red   = w_pwm[RED_LSB];
    assign pwm_green = w_pwm[GREEN_LSB];
    assign pwm_blue  = w_pwm[BLUE_LSB];
endmodule
